jtag_dtm: RTL and testbench

JTAG Debug Transport Module: the initiating end of the DMI link. It decodes an IEEE 1149.1 TAP driven from an external probe and issues DMI read/write requests to the debug module over a `DMIPort` master modport. TCK, TMS and TDI are oversampled in the `clk` domain, so the block has a single clock domain and no asynchronous crossings beyond the input synchronizers.

---
 rtl/jtag_dtm_if.sv | 33 +++
 rtl/jtag_dtm.sv | 254 +++++++++++++++++++++++++
 tb/tb_jtag_dtm.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_dtm_if.sv
// DMIPort: request/response link between the DTM (master) and the debug module.
`ifndef ABITS
`define ABITS 7
`endif

interface DMIPort #(
  parameter int ABITS = `ABITS
);
  logic             valid;
  logic             write_en;
  logic [ABITS-1:0] addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             ready;

  modport Master (
    output valid,
    output write_en,
    output addr,
    output wdata,
    input  rdata,
    input  ready
  );

  modport Slave (
    input  valid,
    input  write_en,
    input  addr,
    input  wdata,
    output rdata,
    output ready
  );
endinterface

// File: rtl/jtag_dtm.sv
// jtag_dtm: JTAG debug transport module. Oversamples the TAP pins in the clk
// domain, runs the 1149.1 TAP, and turns DMI scans into DMIPort requests.
`ifndef ABITS
`define ABITS 7
`endif

module jtag_dtm #(
  parameter int          ABITS       = `ABITS,
  parameter logic [31:0] IDCODE      = 32'h1000_0001,
  parameter int          SYNC_STAGES = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   test_mode,
  input  logic   tck_i,
  input  logic   tms_i,
  input  logic   tdi_i,
  output logic   tdo_o,
  output logic   tdo_oe_o,
  DMIPort.Master dm
);

  localparam int DMI_W = ABITS + 34;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_t;

  typedef enum logic {
    M_IDLE,
    M_REQ
  } m_state_t;

  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
  logic                   tck_prev;
  logic                   tck_s, tms_s, tdi_s;
  logic                   tck_rise, tck_fall;

  tap_state_t tap_state, tap_next;
  logic       capture_dr, shift_dr, update_dr;
  logic       capture_ir, shift_ir, update_ir;

  logic [4:0]       ir, ir_shift;
  logic             sel_idcode, sel_dtmcs, sel_dmi;
  logic [DMI_W-1:0] dr_shift;
  logic [1:0]       dmi_op;
  logic [31:0]      dmi_data;
  logic [ABITS-1:0] dmi_addr;

  logic [1:0]       dmistat;
  logic [ABITS-1:0] last_addr;
  logic [31:0]      last_rdata;
  logic [31:0]      dtmcs_val;
  logic [1:0]       cap_op;
  logic [31:0]      cap_rdata;

  m_state_t m_state, m_next;
  logic     issue, busy_hit, abort, stat_clear, req_done;

  logic unused_test_mode;
  assign unused_test_mode = test_mode;

  // Bring the asynchronous pins into clk through a shift chain and remember last tck
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_prev <= 1'b0;
    end else begin
      tck_sync[0] <= tck_i;
      tms_sync[0] <= tms_i;
      tdi_sync[0] <= tdi_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        tck_sync[i] <= tck_sync[i-1];
        tms_sync[i] <= tms_sync[i-1];
        tdi_sync[i] <= tdi_sync[i-1];
      end
      tck_prev <= tck_sync[SYNC_STAGES-1];
    end
  end

  assign tck_s    = tck_sync[SYNC_STAGES-1];
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev;
  assign tck_fall = ~tck_s & tck_prev;

  // TAP state register
  always_ff @(posedge clk) begin
    if (rst) tap_state <= TEST_LOGIC_RESET;
    else     tap_state <= tap_next;
  end

  // TAP next state, advanced only on a synchronized tck rise
  always_comb begin
    tap_next = tap_state;
    if (tck_rise) begin
      case (tap_state)
        TEST_LOGIC_RESET: tap_next = tms_s ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    tap_next = tms_s ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_DR:        tap_next = tms_s ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR:       tap_next = tms_s ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR:         tap_next = tms_s ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR:         tap_next = tms_s ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:         tap_next = tms_s ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR:         tap_next = tms_s ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:        tap_next = tms_s ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_IR:        tap_next = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       tap_next = tms_s ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR:         tap_next = tms_s ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR:         tap_next = tms_s ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:         tap_next = tms_s ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR:         tap_next = tms_s ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:        tap_next = tms_s ? SELECT_DR : RUN_TEST_IDLE;
        default:          tap_next = TEST_LOGIC_RESET;
      endcase
    end
  end

  // TAP action strobes; update fires on the rise that enters the Update state
  always_comb begin
    capture_dr = tck_rise && (tap_state == CAPTURE_DR);
    shift_dr   = tck_rise && (tap_state == SHIFT_DR);
    update_dr  = tck_rise && (tap_next == UPDATE_DR) && (tap_state != UPDATE_DR);
    capture_ir = tck_rise && (tap_state == CAPTURE_IR);
    shift_ir   = tck_rise && (tap_state == SHIFT_IR);
    update_ir  = tck_rise && (tap_next == UPDATE_IR) && (tap_state != UPDATE_IR);
  end

  // Instruction decode; anything unrecognised falls back to the bypass bit
  always_comb begin
    sel_idcode = (ir == 5'h01);
    sel_dtmcs  = (ir == 5'h10);
    sel_dmi    = (ir == 5'h11);
  end

  // Instruction register and its shift stage
  always_ff @(posedge clk) begin
    if (rst) begin
      ir       <= 5'h01;
      ir_shift <= 5'h00;
    end else begin
      if (tap_state == TEST_LOGIC_RESET) ir <= 5'h01;
      else if (update_ir)                ir <= ir_shift;
      if (capture_ir)    ir_shift <= 5'b00001;
      else if (shift_ir) ir_shift <= {tdi_s, ir_shift[4:1]};
    end
  end

  assign dmi_op   = dr_shift[1:0];
  assign dmi_data = dr_shift[33:2];
  assign dmi_addr = dr_shift[DMI_W-1:34];

  assign dtmcs_val = {14'b0, 3'b000, 3'd1, dmistat, 6'(ABITS), 4'd1};

  // Capture sees a request completing this cycle as already finished
  always_comb begin
    cap_op    = dmistat;
    cap_rdata = last_rdata;
    if (m_state == M_REQ) begin
      if (!dm.ready)           cap_op    = 2'd3;
      else if (!dm.write_en)   cap_rdata = dm.rdata;
    end
  end

  // Data register: capture per selected instruction, shift into that register's MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      dr_shift <= '0;
    end else if (capture_dr) begin
      if (sel_idcode)     dr_shift <= DMI_W'(IDCODE);
      else if (sel_dtmcs) dr_shift <= DMI_W'(dtmcs_val);
      else if (sel_dmi)   dr_shift <= {last_addr, cap_rdata, cap_op};
      else                dr_shift <= '0;
    end else if (shift_dr) begin
      if (sel_dmi)                     dr_shift <= {tdi_s, dr_shift[DMI_W-1:1]};
      else if (sel_idcode || sel_dtmcs) dr_shift[31:0] <= {tdi_s, dr_shift[31:1]};
      else                             dr_shift[0] <= tdi_s;
    end
  end

  // TDO and its enable follow the falling edge of tck
  always_ff @(posedge clk) begin
    if (rst) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else if (tck_fall) begin
      tdo_oe_o <= (tap_state == SHIFT_IR) || (tap_state == SHIFT_DR);
      tdo_o    <= (tap_state == SHIFT_IR) ? ir_shift[0] : dr_shift[0];
    end
  end

  // Update-DR decisions for the DMI and DTMCS registers
  always_comb begin
    issue      = update_dr && sel_dmi && (dmistat == 2'd0) && (m_state == M_IDLE) &&
                 ((dmi_op == 2'd1) || (dmi_op == 2'd2));
    busy_hit   = update_dr && sel_dmi && (dmistat == 2'd0) && (m_state == M_REQ);
    abort      = update_dr && sel_dtmcs && dr_shift[17];
    stat_clear = update_dr && sel_dtmcs && (dr_shift[16] || dr_shift[17]);
  end

  // Master state register
  always_ff @(posedge clk) begin
    if (rst) m_state <= M_IDLE;
    else     m_state <= m_next;
  end

  // Master next state: leave REQ on handshake or abort
  always_comb begin
    m_next = m_state;
    case (m_state)
      M_IDLE:  if (issue) m_next = M_REQ;
      M_REQ:   if (abort || dm.ready) m_next = M_IDLE;
      default: m_next = M_IDLE;
    endcase
  end

  // Master outputs
  always_comb begin
    dm.valid = (m_state == M_REQ);
    req_done = (m_state == M_REQ) && dm.ready && !abort;
  end

  // Request fields are latched at issue and held stable through REQ
  always_ff @(posedge clk) begin
    if (rst) begin
      dm.addr     <= '0;
      dm.wdata    <= '0;
      dm.write_en <= 1'b0;
    end else if (issue) begin
      dm.addr     <= dmi_addr;
      dm.write_en <= (dmi_op == 2'd2);
      if (dmi_op == 2'd2) dm.wdata <= dmi_data;
    end
  end

  // Sticky status, last address and last read data
  always_ff @(posedge clk) begin
    if (rst) begin
      dmistat    <= 2'd0;
      last_addr  <= '0;
      last_rdata <= '0;
    end else begin
      if (stat_clear)    dmistat <= 2'd0;
      else if (busy_hit) dmistat <= 2'd3;
      if (issue) last_addr <= dmi_addr;
      if (req_done && !dm.write_en) last_rdata <= dm.rdata;
    end
  end

endmodule

// File: tb/tb_jtag_dtm.sv
// tb_jtag_dtm: directed JTAG scans against jtag_dtm with a queue of expected results.
module tb_jtag_dtm;

  localparam int ABITS = 7;

  logic clk = 1'b0;
  logic rst, test_mode, tck_i, tms_i, tdi_i;
  logic tdo_o, tdo_oe_o;

  DMIPort #(.ABITS(ABITS)) dmi_bus ();

  jtag_dtm #(
    .ABITS(ABITS),
    .IDCODE(32'h1000_0001),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .test_mode(test_mode),
    .tck_i(tck_i),
    .tms_i(tms_i),
    .tdi_i(tdi_i),
    .tdo_o(tdo_o),
    .tdo_oe_o(tdo_oe_o),
    .dm(dmi_bus)
  );

  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  logic [39:0] obs_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic        valid_prev = 1'b0;
  int          valid_cycles = 0;

  // Record each request as it is presented and count cycles with valid high
  always @(negedge clk) begin
    valid_prev <= dmi_bus.valid;
    if (dmi_bus.valid === 1'b1) valid_cycles <= valid_cycles + 1;
    if (dmi_bus.valid === 1'b1 && valid_prev !== 1'b1)
      obs_q.push_back({dmi_bus.write_en, dmi_bus.addr, dmi_bus.wdata});
  end

  task automatic expect_value(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed);
    logic [63:0] expected;
    total_cnt++;
    if (exp_q.size() == 0) expected = 'x;
    else                   expected = exp_q.pop_front();
    assert (observed === expected) pass_cnt++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
  endtask

  function automatic logic [39:0] pop_obs();
    if (obs_q.size() == 0) return 'x;
    return obs_q.pop_front();
  endfunction

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                           input logic [1:0] op);
    return {23'b0, a, d, op};
  endfunction

  // One full TCK period; TDO/OE are sampled just before the rising edge
  task automatic apply_stimulus(input logic tms, input logic tdi,
                                output logic tdo, output logic oe);
    tms_i = tms;
    tdi_i = tdi;
    repeat (4) @(negedge clk);
    tdo = tdo_o;
    oe  = tdo_oe_o;
    tck_i = 1'b1;
    repeat (4) @(negedge clk);
    tck_i = 1'b0;
  endtask

  // IR or DR scan from Run-Test/Idle back to Run-Test/Idle
  task automatic scan(input logic is_ir, input logic [63:0] data, input int len,
                      output logic [63:0] out, output logic [2:0] oe_pat);
    logic t, o, during;
    out    = '0;
    during = 1'b1;
    apply_stimulus(1'b1, 1'b0, t, o);
    if (is_ir) apply_stimulus(1'b1, 1'b0, t, o);
    apply_stimulus(1'b0, 1'b0, t, o);
    apply_stimulus(1'b0, 1'b0, t, o);
    oe_pat[2] = o;
    for (int i = 0; i < len; i++) begin
      apply_stimulus(i == len - 1, data[i], t, o);
      out[i] = t;
      during &= o;
    end
    apply_stimulus(1'b1, 1'b0, t, o);
    oe_pat[0] = o;
    apply_stimulus(1'b0, 1'b0, t, o);
    oe_pat[1] = during;
  endtask

  logic [63:0] out;
  logic [2:0]  oe_pat;
  logic        t, o;
  int          vc0;

  initial begin
    rst = 1'b1; test_mode = 1'b0; tck_i = 1'b0; tms_i = 1'b1; tdi_i = 1'b0;
    dmi_bus.ready = 1'b1;
    dmi_bus.rdata = 32'h0000_0382;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (6) expect_value(64'h0);
    @(negedge clk);
    check_output("rst_tdo", tdo_o);
    check_output("rst_tdo_oe", tdo_oe_o);
    check_output("rst_valid", dmi_bus.valid);
    check_output("rst_write_en", dmi_bus.write_en);
    check_output("rst_addr", dmi_bus.addr);
    check_output("rst_wdata", dmi_bus.wdata);

    // IDCODE after TAP reset
    repeat (5) apply_stimulus(1'b1, 1'b0, t, o);
    apply_stimulus(1'b0, 1'b0, t, o);
    expect_value(64'h1000_0001);
    expect_value(64'b010);
    scan(1'b0, 64'h0, 32, out, oe_pat);
    check_output("idcode", out);
    check_output("idcode_oe", oe_pat);

    // DTMCS read
    expect_value(64'h01);
    scan(1'b1, 64'h10, 5, out, oe_pat);
    check_output("ir_cap_dtmcs", out);
    expect_value(64'h0000_1071);
    scan(1'b0, 64'h0, 32, out, oe_pat);
    check_output("dtmcs_read", out);

    // DMI write
    expect_value(64'h01);
    scan(1'b1, 64'h11, 5, out, oe_pat);
    check_output("ir_cap_dmi", out);
    vc0 = valid_cycles;
    expect_value(dmi_word(7'h00, 32'h0, 2'd0));
    scan(1'b0, dmi_word(7'h10, 32'h8000_0001, 2'd2), 41, out, oe_pat);
    check_output("dmi_cap_pre_write", out);
    repeat (4) @(negedge clk);
    expect_value(64'd1);
    check_output("write_valid_cycles", valid_cycles - vc0);
    expect_value({24'b0, 1'b1, 7'h10, 32'h8000_0001});
    check_output("write_txn", pop_obs());

    // DMI read then nop to fetch the result
    expect_value(dmi_word(7'h10, 32'h0, 2'd0));
    scan(1'b0, dmi_word(7'h11, 32'h0, 2'd1), 41, out, oe_pat);
    check_output("dmi_cap_pre_read", out);
    expect_value({56'b0, 1'b0, 7'h11});
    check_output("read_txn", pop_obs() >> 32);
    expect_value(dmi_word(7'h11, 32'h0000_0382, 2'd0));
    scan(1'b0, 64'h0, 41, out, oe_pat);
    check_output("read_result", out);

    // Busy: responder stalls
    dmi_bus.ready = 1'b0;
    expect_value(dmi_word(7'h11, 32'h0000_0382, 2'd0));
    scan(1'b0, dmi_word(7'h12, 32'h0, 2'd1), 41, out, oe_pat);
    check_output("busy_cap_first", out);
    expect_value({56'b0, 1'b0, 7'h12});
    check_output("busy_read_txn", pop_obs() >> 32);
    expect_value(dmi_word(7'h12, 32'h0000_0382, 2'd3));
    scan(1'b0, dmi_word(7'h13, 32'h0, 2'd1), 41, out, oe_pat);
    check_output("busy_cap_busy", out);
    expect_value(dmi_word(7'h12, 32'h0000_0382, 2'd3));
    scan(1'b0, dmi_word(7'h14, 32'h1234, 2'd2), 41, out, oe_pat);
    check_output("busy_cap_sticky", out);
    expect_value(dmi_word(7'h12, 32'h0000_0382, 2'd3));
    scan(1'b0, 64'h0, 41, out, oe_pat);
    check_output("busy_ops_ignored", out);
    expect_value(64'd0);
    check_output("no_extra_txn", obs_q.size());

    // DTMCS clear and abort
    expect_value(64'h01);
    scan(1'b1, 64'h10, 5, out, oe_pat);
    check_output("ir_cap_dtmcs2", out);
    expect_value(64'h0000_1C71);
    scan(1'b0, 64'h0001_0000, 32, out, oe_pat);
    check_output("dtmcs_stat3", out);
    expect_value(64'd1);
    check_output("valid_after_clear", dmi_bus.valid);
    expect_value(64'h0000_1071);
    scan(1'b0, 64'h0002_0000, 32, out, oe_pat);
    check_output("dtmcs_stat_cleared", out);
    repeat (2) @(negedge clk);
    expect_value(64'd0);
    check_output("valid_after_abort", dmi_bus.valid);
    dmi_bus.rdata = 32'hDEAD_BEEF;
    dmi_bus.ready = 1'b1;
    expect_value(64'h01);
    scan(1'b1, 64'h11, 5, out, oe_pat);
    check_output("ir_cap_dmi2", out);
    expect_value(dmi_word(7'h12, 32'h0000_0382, 2'd0));
    scan(1'b0, 64'h0, 41, out, oe_pat);
    check_output("rdata_kept_after_abort", out);

    // BYPASS via 0x1F and via an unused code
    expect_value(64'h01);
    scan(1'b1, 64'h1F, 5, out, oe_pat);
    check_output("ir_cap_bypass", out);
    expect_value(64'h14A);
    expect_value(64'b010);
    scan(1'b0, 64'h0A5, 9, out, oe_pat);
    check_output("bypass_1f", out);
    check_output("bypass_1f_oe", oe_pat);
    expect_value(64'h01);
    scan(1'b1, 64'h05, 5, out, oe_pat);
    check_output("ir_cap_unused", out);
    expect_value(64'h14A);
    scan(1'b0, 64'h0A5, 9, out, oe_pat);
    check_output("bypass_05", out);

    // Reset in the middle of a stalled request
    dmi_bus.ready = 1'b0;
    expect_value(64'h01);
    scan(1'b1, 64'h11, 5, out, oe_pat);
    check_output("ir_cap_dmi3", out);
    expect_value(dmi_word(7'h12, 32'h0000_0382, 2'd0));
    scan(1'b0, dmi_word(7'h20, 32'h0, 2'd1), 41, out, oe_pat);
    check_output("dmi_cap_pre_rst", out);
    expect_value({56'b0, 1'b0, 7'h20});
    check_output("rst_read_txn", pop_obs() >> 32);
    expect_value(64'd1);
    check_output("valid_before_rst", dmi_bus.valid);
    rst = 1'b1;
    expect_value(64'd0);
    @(negedge clk);
    check_output("valid_after_rst", dmi_bus.valid);
    rst = 1'b0;
    dmi_bus.ready = 1'b1;
    apply_stimulus(1'b0, 1'b0, t, o);
    expect_value(64'h1000_0001);
    scan(1'b0, 64'h0, 32, out, oe_pat);
    check_output("idcode_after_rst", out);

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
